// File: rtl/swu_ram_ctrl.sv
// swu_ram_ctrl: sliding-window read controller for a dual-port RAM used as a line buffer.
//
// Input words (WIDTHA bits, RATIO elements each) are written through port A as they arrive.
// For every output position o and tap k the controller reads element idx = o*STRIDE - PAD + k
// through port B. Out-of-range indices are padding and are zeroed at capture instead of read.
// Port B is two-stage: enaB loads the RAM read register, enaB_q loads doB, and out_valid
// flags doB.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   in_valid / in_ready  write-word handshake (word data goes straight to RAM diA)
//   weA, enaA, addrA     RAM write port controls
//   enaB, enaB_q         RAM read-register and output-register enables
//   zeropad              force doB to zero at the enaB_q capture
//   addrB                RAM read element address
//   out_valid/out_ready  handshake for RAM doB
//   frame_done           one-cycle pulse when a frame has fully drained
module swu_ram_ctrl #(
    parameter int WIDTHA  = 32,
    parameter int WIDTHB  = 8,
    parameter int DEPTHA  = 4,
    parameter int IFM_DIM = 8,
    parameter int K       = 3,
    parameter int STRIDE  = 1,
    parameter int PAD     = 1,
    localparam int RATIO      = WIDTHA / WIDTHB,
    localparam int LOG2RATIO  = $clog2(RATIO),
    localparam int ADDRWIDTHA = $clog2(DEPTHA),
    localparam int ADDRWIDTHB = ADDRWIDTHA + LOG2RATIO
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  weA,
    output logic                  enaA,
    output logic [ADDRWIDTHA-1:0] addrA,
    output logic                  enaB,
    output logic                  enaB_q,
    output logic                  zeropad,
    output logic [ADDRWIDTHB-1:0] addrB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done
);

    localparam int OFM_DIM  = (IFM_DIM + 2 * PAD - K) / STRIDE + 1;
    localparam int IN_WORDS = IFM_DIM / RATIO;
    // Signed width wide enough for element indices, window bases and word-element products.
    localparam int IW = $clog2(IFM_DIM + 2 * PAD + K + STRIDE + DEPTHA * RATIO) + 2;
    localparam int OW = $clog2(OFM_DIM + 1);
    localparam int KW = $clog2(K + 1);
    localparam int WW = $clog2(IN_WORDS + 1);

    localparam logic signed [IW-1:0] IfmDimS   = IW'(IFM_DIM);
    localparam logic signed [IW-1:0] DepthS    = IW'(DEPTHA);
    localparam logic signed [IW-1:0] StrideS   = IW'(STRIDE);
    localparam logic signed [IW-1:0] BaseInit  = IW'(-PAD);
    localparam logic [WW-1:0]        InWordsW  = WW'(IN_WORDS);
    localparam logic [KW-1:0]        KLast     = KW'(K - 1);
    localparam logic [OW-1:0]        OLast     = OW'(OFM_DIM - 1);

    typedef enum logic {StRun, StDrain} stateE;

    stateE                 stateQ, stateD;
    logic [WW-1:0]         wrCntQ;
    logic [OW-1:0]         oCntQ;
    logic [KW-1:0]         kCntQ;
    logic signed [IW-1:0]  baseIdxQ;   // o*STRIDE - PAD, stepped by STRIDE per window
    logic                  s1ValidQ, s1PadQ, outValidQ;

    logic signed [IW-1:0]  idx, wrElems, wrCntS, lowWord;
    logic                  isPad, avail, issue, advance, write, lastElem, frameEnd, ready;

    always_comb begin
        idx      = baseIdxQ + IW'(kCntQ);
        wrElems  = IW'(wrCntQ) << LOG2RATIO;
        wrCntS   = IW'(wrCntQ);
        // Oldest word still needed by the current window; a shift, since RATIO is a power of 2.
        lowWord  = (baseIdxQ > 0) ? (baseIdxQ >>> LOG2RATIO) : '0;
        isPad    = (idx < 0) || (idx >= IfmDimS);
        avail    = idx < wrElems;
        advance  = !outValidQ || out_ready;
        issue    = (stateQ == StRun) && (isPad || avail);
        lastElem = (kCntQ == KLast) && (oCntQ == OLast);
        frameEnd = (stateQ == StDrain) && (wrCntQ == InWordsW) && !s1ValidQ && advance;
        // Never overwrite a RAM word the current window may still read.
        ready    = (stateQ == StRun) && (wrCntQ < InWordsW) && ((wrCntS - lowWord) < DepthS);
        write    = in_valid && ready;

        stateD = stateQ;
        unique case (stateQ)
            StRun:   if (issue && advance && lastElem) stateD = StDrain;
            StDrain: if (frameEnd) stateD = StRun;
            default: stateD = StRun;
        endcase
    end

    // Control outputs are forced low during reset.
    always_comb begin
        in_ready   = !rst && ready;
        weA        = !rst && write;
        enaA       = !rst && write;
        enaB       = !rst && issue && advance && !isPad;
        enaB_q     = !rst && s1ValidQ && advance;
        zeropad    = !rst && s1PadQ;
        frame_done = !rst && frameEnd;
        addrA      = rst ? '0 : ADDRWIDTHA'(wrCntQ);
        addrB      = rst ? '0 : idx[ADDRWIDTHB-1:0];
        out_valid  = outValidQ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= StRun;
            wrCntQ    <= '0;
            oCntQ     <= '0;
            kCntQ     <= '0;
            baseIdxQ  <= BaseInit;
            s1ValidQ  <= 1'b0;
            s1PadQ    <= 1'b0;
            outValidQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (write) wrCntQ <= wrCntQ + 1'b1;
            if (advance) begin
                s1ValidQ  <= issue;
                s1PadQ    <= isPad;
                outValidQ <= s1ValidQ;
                if (issue) begin
                    if (kCntQ == KLast) begin
                        kCntQ    <= '0;
                        oCntQ    <= oCntQ + 1'b1;
                        baseIdxQ <= baseIdxQ + StrideS;
                    end else begin
                        kCntQ <= kCntQ + 1'b1;
                    end
                end
            end
            // Restart the next frame; Drain never writes or issues, so nothing else competes.
            if (frameEnd) begin
                wrCntQ   <= '0;
                oCntQ    <= '0;
                kCntQ    <= '0;
                baseIdxQ <= BaseInit;
            end
        end
    end

endmodule

// File: tb/tb_swu_ram_ctrl.sv
// Bench for swu_ram_ctrl: a behavioural RAM sits on the A/B ports, a scoreboard queue holds
// the expected doB stream, and a monitor pops it on every out_valid & out_ready.
// Element i of frame f carries value f*16 + i + 1, so padding (0) and stale frames stand out.
module tb_swu_ram_ctrl;

    logic        clk, rst;
    logic        inValid, inReady, weA, enaA, enaB, enaBQ, zeropad, outValid, outReady, frameDone;
    logic [1:0]  addrA;
    logic [3:0]  addrB;
    logic [31:0] diA;

    // Second instance: shallow RAM, wide frame, only its write back-pressure is observed.
    logic        inValid2, inReady2, weA2, enaA2, enaB2, enaBQ2, zeropad2, outValid2, outReady2;
    logic        frameDone2;
    logic [0:0]  addrA2;
    logic [2:0]  addrB2;

    swu_ram_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .weA(weA), .enaA(enaA), .addrA(addrA),
        .enaB(enaB), .enaB_q(enaBQ), .zeropad(zeropad), .addrB(addrB),
        .out_valid(outValid), .out_ready(outReady), .frame_done(frameDone)
    );

    swu_ram_ctrl #(.DEPTHA(2), .IFM_DIM(16)) dut2 (
        .clk(clk), .rst(rst), .in_valid(inValid2), .in_ready(inReady2),
        .weA(weA2), .enaA(enaA2), .addrA(addrA2),
        .enaB(enaB2), .enaB_q(enaBQ2), .zeropad(zeropad2), .addrB(addrB2),
        .out_valid(outValid2), .out_ready(outReady2), .frame_done(frameDone2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 4 x 32-bit words, byte-addressed reads, two-stage read port.
    logic [31:0] mem [4];
    logic [7:0]  readB, doB;
    always @(posedge clk) begin
        if (weA) mem[addrA] <= diA;
        if (enaB) readB <= mem[addrB[3:2]][addrB[1:0]*8 +: 8];
        if (enaBQ) doB <= zeropad ? 8'h00 : readB;
    end

    logic [7:0] expQ [$];
    int compared = 0, failed = 0, popped = 0, fdCnt = 0;
    bit randReady = 0;

    function automatic logic [7:0] val(input int f, input int i);
        return 8'(f * 16 + i + 1);
    endfunction

    function automatic logic [31:0] word(input int f, input int w);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = val(f, 4 * w + j);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // 8 windows x 3 taps of frame f; idx = o - 1 + k, outside 0..7 is padding.
    task automatic pushFrame(input int f);
        for (int o = 0; o < 8; o++)
            for (int k = 0; k < 3; k++) begin
                int idx = o - 1 + k;
                expQ.push_back((idx < 0 || idx >= 8) ? 8'h00 : val(f, idx));
            end
    endtask

    task automatic tick();
        @(negedge clk);
        if (randReady) outReady = 1'($urandom_range(0, 1));
    endtask

    task automatic sendWord(input logic [31:0] w);
        int n = 0;
        diA = w;
        inValid = 1'b1;
        #2;
        while (!inReady && n < 500) begin
            tick();
            #2;
            n++;
        end
        if (!inReady) check("in_ready_timeout", 0, 1);
        tick();
        inValid = 1'b0;
    endtask

    task automatic resetDut();
        tick();
        rst = 1'b1;
        expQ.delete();
        #2;
        check("rst_in_ready", int'(inReady), 0);
        check("rst_enaB", int'(enaB), 0);
        check("rst_frame_done", int'(frameDone), 0);
        tick();
        tick();
        rst = 1'b0;
        popped = 0;
        fdCnt = 0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        check(name, expQ.size(), 0);
        repeat (5) tick();
    endtask

    // Monitor: compares doB against the scoreboard on every accepted output.
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst && frameDone) fdCnt++;
        if (!rst && outValid && outReady) begin
            compared++;
            if (expQ.size() == 0) begin
                failed++;
                $display("FAIL unexpected_output: got %0h, required no output", doB);
            end else begin
                logic [7:0] e;
                e = expQ.pop_front();
                popped++;
                if (doB !== e) begin
                    failed++;
                    $display("FAIL element_%0d: got %0h, required %0h", popped - 1, doB, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [3:0] snapAddr;
        logic       snapPad;
        rst = 1'b1; inValid = 1'b0; diA = '0; outReady = 1'b1;
        inValid2 = 1'b0; outReady2 = 1'b1;

        // Full frame, free-flowing output.
        resetDut();
        pushFrame(1);
        expQ.push_back(8'h00);  // first pad of the following, unfed frame
        #2;
        check("post_rst_out_valid", int'(outValid), 0);
        check("post_rst_zeropad", int'(zeropad), 0);
        check("post_rst_addrA", int'(addrA), 0);
        tick();
        sendWord(word(1, 0));
        sendWord(word(1, 1));
        waitDrain("A_drain");
        check("A_frame_done", fdCnt, 1);
        check("A_count", popped, 25);

        // Only word 0 available: 11 elements, then the stream stalls.
        resetDut();
        pushFrame(2);
        expQ.push_back(8'h00);
        sendWord(word(2, 0));
        repeat (30) tick();
        #2;
        check("B_partial_count", popped, 11);
        check("B_stalled_out_valid", int'(outValid), 0);
        sendWord(word(2, 1));
        waitDrain("B_drain");
        check("B_frame_done", fdCnt, 1);

        // Output back-pressure for 5 cycles.
        resetDut();
        pushFrame(3);
        expQ.push_back(8'h00);
        sendWord(word(3, 0));
        sendWord(word(3, 1));
        n = 0;
        while (popped < 5 && n < 100) begin
            tick();
            n++;
        end
        outReady = 1'b0;
        #2;
        snapAddr = addrB;
        snapPad  = zeropad;
        check("C_hold_out_valid", int'(outValid), 1);
        check("C_hold_enaB", int'(enaB), 0);
        check("C_hold_enaB_q", int'(enaBQ), 0);
        for (int i = 1; i < 5; i++) begin
            tick();
            #2;
            check("C_hold_out_valid", int'(outValid), 1);
            check("C_hold_addrB", int'(addrB), int'(snapAddr));
            check("C_hold_zeropad", int'(zeropad), int'(snapPad));
            check("C_hold_enaB", int'(enaB), 0);
            check("C_hold_enaB_q", int'(enaBQ), 0);
        end
        tick();
        outReady = 1'b1;
        waitDrain("C_drain");
        check("C_frame_done", fdCnt, 1);

        // Reset in the middle of window 4, then a fresh frame.
        resetDut();
        pushFrame(4);
        sendWord(word(4, 0));
        sendWord(word(4, 1));
        n = 0;
        while (popped < 11 && n < 100) begin
            tick();
            n++;
        end
        tick();
        rst = 1'b1;
        expQ.delete();
        #2;
        check("E_rst_weA", int'(weA), 0);
        check("E_rst_enaB_q", int'(enaBQ), 0);
        check("E_rst_zeropad", int'(zeropad), 0);
        check("E_rst_addrB", int'(addrB), 0);
        tick();
        rst = 1'b0;
        popped = 0;
        fdCnt = 0;
        pushFrame(5);
        expQ.push_back(8'h00);
        #2;
        check("E_after_out_valid", int'(outValid), 0);
        check("E_after_zeropad", int'(zeropad), 0);
        check("E_after_enaB_q", int'(enaBQ), 0);
        check("E_after_frame_done", int'(frameDone), 0);
        tick();
        sendWord(word(5, 0));
        sendWord(word(5, 1));
        waitDrain("E_drain");
        check("E_frame_done", fdCnt, 1);

        // Three back-to-back frames with random output back-pressure.
        resetDut();
        randReady = 1;
        for (int f = 6; f < 9; f++) pushFrame(f);
        expQ.push_back(8'h00);
        for (int f = 6; f < 9; f++) begin
            sendWord(word(f, 0));
            sendWord(word(f, 1));
        end
        waitDrain("D_drain");
        randReady = 0;
        outReady = 1'b1;
        check("D_frame_done", fdCnt, 3);
        check("D_count", popped, 73);

        // DEPTHA=2 instance: in_ready drops after 2 words and returns when window 5 starts.
        inValid2 = 1'b1;
        resetDut();
        expQ.push_back(8'h00);  // main instance emits its first pad with no words supplied
        for (int c = 0; c < 20; c++) begin
            #2;
            check($sformatf("in_ready2_c%0d", c), int'(inReady2), (c < 2 || c == 15) ? 1 : 0);
            tick();
        end
        inValid2 = 1'b0;
        waitDrain("F_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/swu_ram_ctrl.md
SWU_RAM_CTRL -- requirements
Module: swu_ram_ctrl

Interface
REQ-001 SHALL have parameter WIDTHA, default 32: RAM write-word width in bits.
REQ-002 SHALL have parameter WIDTHB, default 8: element width in bits; RATIO = WIDTHA/WIDTHB SHALL be a power of 2.
REQ-003 SHALL have parameter DEPTHA, default 4: RAM depth in write words, a power of 2; ADDRWIDTHA = log2(DEPTHA), ADDRWIDTHB = ADDRWIDTHA + log2(RATIO).
REQ-004 SHALL have parameters IFM_DIM (default 8, a multiple of RATIO), K (default 3), STRIDE (default 1) and PAD (default 1); OFM_DIM = (IFM_DIM + 2*PAD - K)/STRIDE + 1; IN_WORDS = IFM_DIM/RATIO; legal only if DEPTHA*RATIO >= K + RATIO.
REQ-005 SHALL have ports: clk in 1 (single clock, rising edge); rst in 1 (synchronous, active-high reset).
REQ-006 SHALL have ports: in_valid in 1, in_ready out 1 (write-word handshake; data routes directly to RAM diA).
REQ-007 SHALL have ports: weA out 1, enaA out 1, addrA out ADDRWIDTHA (RAM write port).
REQ-008 SHALL have ports: enaB out 1, enaB_q out 1, zeropad out 1, addrB out ADDRWIDTHB (RAM two-stage read port).
REQ-009 SHALL have ports: out_valid out 1, out_ready in 1 (handshake for RAM doB); frame_done out 1 (one-cycle pulse).

Function
REQ-010 SHALL emit, per frame, windows o = 0..OFM_DIM-1 and taps k = 0..K-1, k fastest, element index idx = o*STRIDE - PAD + k (signed).
REQ-011 SHALL treat idx < 0 or idx >= IFM_DIM as a pad element: no RAM read is needed and zeropad = 1 is used at capture.
REQ-012 SHALL treat a non-pad element as available only when idx < wr_cnt*RATIO, where wr_cnt counts words written this frame.
REQ-013 SHALL drive addrB = idx modulo DEPTHA*RATIO (low ADDRWIDTHB bits) and addrA = wr_cnt modulo DEPTHA.
REQ-014 SHALL compute low_word = 0 if o*STRIDE - PAD <= 0, else floor((o*STRIDE - PAD)/RATIO), using incremental counters (no multiplier).
REQ-015 SHALL assert in_ready only when all of the following hold: state RUN, wr_cnt < IN_WORDS, and wr_cnt - low_word < DEPTHA.
REQ-016 SHALL assert weA = enaA = in_valid & in_ready, and increment wr_cnt on each such cycle.
REQ-017 SHALL define advance = !out_valid | out_ready (combinational from out_ready).
REQ-018 SHALL define issue = (state RUN) & (element counters not exhausted) & (pad | available).
REQ-019 SHALL assert enaB = issue & advance & !pad and enaB_q = s1_valid & advance; the zeropad output equals the registered stage-1 pad flag.
REQ-020 SHALL, on advance, load s1_valid <= issue and s1_pad <= pad, set out_valid <= s1_valid, and step (k, o) when issue is high.
REQ-021 SHALL hold s1_valid, s1_pad, out_valid and the counters while advance is low; RAM readB and doB are held because enaB and enaB_q are low.
REQ-022 SHALL have read latency issue -> out_valid of 2 cycles with no backpressure, sustaining 1 element per cycle.
REQ-023 SHALL use FSM states RUN -> DRAIN -> RUN: RUN goes to DRAIN after the last element issues; DRAIN goes to RUN when wr_cnt == IN_WORDS, s1_valid == 0 and out_valid & out_ready are handled, pulsing frame_done, clearing wr_cnt, o and k, and restarting the next frame.
REQ-024 SHALL allow a simultaneous write and read in the same cycle; availability uses the registered wr_cnt, so a word written in cycle t is readable from t+1.

Reset
REQ-025 SHALL, on rst in the same cycle, clear wr_cnt, o, k, s1_valid, s1_pad and out_valid, set state RUN, and hold weA, enaA, enaB, enaB_q, zeropad, frame_done and in_ready low; addrA and addrB reset to 0.
REQ-026 SHALL, when rst is asserted mid-frame, abandon the partial frame; the first element after reset is o=0, k=0 and no stale out_valid appears.

Verification (defaults unless stated)
REQ-027 SHALL pass this test: 2 words streamed, out_ready=1 -> 24 elements with idx sequence -1,0,1,0,1,2,...,6,7,8; zeropad=1 only on the 1st and 24th elements; frame_done pulses once.
REQ-028 SHALL pass this test: after word 0, in_valid=0 -> exactly 11 elements out (windows 0-2 and taps 0-1 of window 3), then out_valid=0 until word 1 is written.
REQ-029 SHALL pass this test: out_ready=0 for 5 cycles with out_valid=1 -> out_valid, zeropad and addrB stable, enaB=enaB_q=0, and no element is lost or duplicated afterwards.
REQ-030 SHALL pass this test: DEPTHA=2, IFM_DIM=16, in_valid=1 -> in_ready drops after 2 words and rises only once window o=5 begins (low_word=1).
REQ-031 SHALL pass this test: rst pulsed mid-window 4 -> all outputs 0 in the next cycle; a fresh frame then reproduces the REQ-027 sequence.
REQ-032 SHALL pass this test: 3 back-to-back frames with random out_ready -> 72 elements, correct data, 3 frame_done pulses.
